// File: rtl/exec_sequencer.sv
// exec_sequencer: IDLE/READ/EXEC/WB instruction sequencer driving an
// external combinational ALU, with a 16x16 register file and debug port.
module exec_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              InValid,
    input  logic [15:0]       InInstr,
    output logic              InReady,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic [15:0]       AluOp,
    input  logic [DATA_W-1:0] AluC,
    input  logic [4:0]        AluFlags,
    output logic [4:0]        Psr,
    output logic              Done,
    output logic              Illegal,
    input  logic [3:0]        DbgAddr,
    input  logic              DbgWe,
    input  logic [DATA_W-1:0] DbgWData,
    output logic [DATA_W-1:0] DbgRData
);
    localparam logic [3:0] RTYPE  = 4'h0;
    localparam logic [3:0] ADDI   = 4'h5;
    localparam logic [3:0] SHIFTS = 4'h8;
    localparam logic [3:0] SUBI   = 4'h9;
    localparam logic [3:0] CMPI   = 4'hB;

    localparam logic [3:0] EXT_AND        = 4'h1;
    localparam logic [3:0] EXT_OR         = 4'h2;
    localparam logic [3:0] EXT_XOR        = 4'h3;
    localparam logic [3:0] EXT_ADD        = 4'h5;
    localparam logic [3:0] EXT_LSHI_LEFT  = 4'h0;
    localparam logic [3:0] EXT_LSHI_RIGHT = 4'h1;
    localparam logic [3:0] EXT_LSH        = 4'h4;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [15:0]       instr;
    logic [DATA_W-1:0] res_c;
    logic [4:0]        res_flags;
    logic [3:0]        op_class;
    logic [3:0]        op_ext;
    logic [3:0]        rdest;
    logic              legal;
    logic              writes;

    // Retire decode works off AluOp, which holds the instruction until the next READ.
    assign op_class = AluOp[15:12];
    assign op_ext   = AluOp[7:4];
    assign rdest    = AluOp[11:8];

    assign InReady  = (state == IDLE);
    assign Done     = (state == WB);
    assign Illegal  = (state == WB) && !legal;
    assign DbgRData = regs[DbgAddr];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (InValid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        legal  = 1'b1;
        writes = 1'b0;
        unique case (op_class)
            RTYPE:
                writes = op_ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD};
            ADDI, SUBI:
                writes = 1'b1;
            SHIFTS:
                writes = op_ext inside {EXT_LSHI_LEFT, EXT_LSHI_RIGHT, EXT_LSH};
            CMPI:
                writes = 1'b0;
            default:
                legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            instr     <= '0;
            AluA      <= '0;
            AluB      <= '0;
            AluOp     <= '0;
            res_c     <= '0;
            res_flags <= '0;
            Psr       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (InValid) instr <= InInstr;
                    // Debug write lands on the accept edge, so READ sees it.
                    if (DbgWe) regs[DbgAddr] <= DbgWData;
                end
                READ: begin
                    AluA  <= regs[instr[11:8]];
                    AluB  <= regs[instr[3:0]];
                    AluOp <= instr;
                end
                EXEC: begin
                    res_c     <= AluC;
                    res_flags <= AluFlags;
                end
                WB: begin
                    Psr <= res_flags;
                    if (writes) regs[rdest] <= res_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: behavioural ALU, reference
// register file / PSR model, directed and randomized instruction streams.
module tb_exec_sequencer;
    localparam logic [3:0] RTYPE  = 4'h0;
    localparam logic [3:0] ADDI   = 4'h5;
    localparam logic [3:0] SHIFTS = 4'h8;
    localparam logic [3:0] SUBI   = 4'h9;
    localparam logic [3:0] CMPI   = 4'hB;

    localparam logic [3:0] EXT_AND        = 4'h1;
    localparam logic [3:0] EXT_OR         = 4'h2;
    localparam logic [3:0] EXT_XOR        = 4'h3;
    localparam logic [3:0] EXT_ADD        = 4'h5;
    localparam logic [3:0] EXT_CMP        = 4'hB;
    localparam logic [3:0] EXT_LSHI_LEFT  = 4'h0;
    localparam logic [3:0] EXT_LSHI_RIGHT = 4'h1;
    localparam logic [3:0] EXT_LSH        = 4'h4;

    localparam int CARRY_F = 0;
    localparam int LOW_F   = 1;
    localparam int FLAG_F  = 2;
    localparam int ZERO_F  = 3;
    localparam int NEG_F   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        InValid;
    logic [15:0] InInstr;
    logic        InReady;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [15:0] AluOp;
    logic [15:0] AluC;
    logic [4:0]  AluFlags;
    logic [4:0]  Psr;
    logic        Done;
    logic        Illegal;
    logic [3:0]  DbgAddr;
    logic        DbgWe;
    logic [15:0] DbgWData;
    logic [15:0] DbgRData;

    int errors = 0;
    int checks = 0;
    logic [15:0] ref_rf [16];
    logic [4:0]  ref_psr;

    exec_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .InValid(InValid), .InInstr(InInstr), .InReady(InReady),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
        .AluC(AluC), .AluFlags(AluFlags), .Psr(Psr),
        .Done(Done), .Illegal(Illegal),
        .DbgAddr(DbgAddr), .DbgWe(DbgWe),
        .DbgWData(DbgWData), .DbgRData(DbgRData)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags, result}.
    function automatic logic [20:0] alu_eval(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [15:0] op);
        logic [3:0]  cls;
        logic [3:0]  ext;
        logic [15:0] y;
        logic [15:0] c;
        logic [16:0] w;
        logic [4:0]  f;
        int          sh;
        cls = op[15:12];
        ext = op[7:4];
        y   = (cls == RTYPE) ? b : {{8{op[7]}}, op[7:0]};
        f   = '0;
        c   = '0;
        if (cls == RTYPE && ext == EXT_ADD || cls == ADDI) begin
            w = {1'b0, a} + {1'b0, y};
            c = w[15:0];
            f[CARRY_F] = w[16];
            f[FLAG_F]  = (a[15] == y[15]) && (c[15] != a[15]);
        end else if (cls == SUBI) begin
            w = {1'b0, a} - {1'b0, y};
            c = w[15:0];
            f[CARRY_F] = w[16];
            f[FLAG_F]  = (a[15] != y[15]) && (c[15] != a[15]);
        end else if (cls == RTYPE && ext == EXT_CMP || cls == CMPI) begin
            c = a - y;
            f[ZERO_F] = (a == y);
            f[LOW_F]  = (a < y);
            f[NEG_F]  = ($signed(a) < $signed(y));
            return {f, c};
        end else if (cls == RTYPE && ext == EXT_AND) c = a & y;
        else if (cls == RTYPE && ext == EXT_OR)  c = a | y;
        else if (cls == RTYPE && ext == EXT_XOR) c = a ^ y;
        else if (cls == SHIFTS && ext == EXT_LSHI_LEFT)  c = a << op[3:0];
        else if (cls == SHIFTS && ext == EXT_LSHI_RIGHT) c = a >> op[3:0];
        else if (cls == SHIFTS && ext == EXT_LSH) begin
            sh = b[4] ? (32 - int'(b[4:0])) : int'(b[4:0]);
            c  = b[4] ? (a >> sh) : (a << sh);
        end else if (cls inside {RTYPE, SHIFTS}) begin
            return {a[4:0] ^ b[4:0], a ^ b};
        end else begin
            return {5'b11111, 16'hFFFF};
        end
        f[ZERO_F] = (c == 16'h0000);
        f[NEG_F]  = c[15];
        return {f, c};
    endfunction

    assign {AluFlags, AluC} = alu_eval(AluA, AluB, AluOp);

    function automatic bit model_writes(input logic [15:0] ins);
        logic [3:0] cls;
        logic [3:0] ext;
        cls = ins[15:12];
        ext = ins[7:4];
        if (cls == ADDI || cls == SUBI) return 1'b1;
        if (cls == RTYPE) return ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD};
        if (cls == SHIFTS)
            return ext inside {EXT_LSHI_LEFT, EXT_LSHI_RIGHT, EXT_LSH};
        return 1'b0;
    endfunction

    function automatic bit model_illegal(input logic [15:0] ins);
        return !(ins[15:12] inside {RTYPE, ADDI, SHIFTS, SUBI, CMPI});
    endfunction

    task automatic dbg_write(input logic [3:0] addr, input logic [15:0] data);
        DbgWe    = 1'b1;
        DbgAddr  = addr;
        DbgWData = data;
        @(negedge clk);
        DbgWe = 1'b0;
        ref_rf[addr] = data;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            DbgAddr = 4'(i);
            #1;
            checks++;
            if (DbgRData !== ref_rf[i]) begin
                errors++;
                $display("FAIL %s R%0d: got %h expected %h", tag, i, DbgRData, ref_rf[i]);
            end
        end
        @(negedge clk);
    endtask

    // dbg_stage: 0 = write with accept, 1..3 = during READ/EXEC/WB, else none.
    task automatic run_instr(input logic [15:0] ins, input bit junk,
                             input int dbg_stage, input logic [3:0] dbg_addr,
                             input logic [15:0] dbg_data);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  f;
        logic [20:0] r;
        logic [3:0]  rd;
        bit          we;
        bit          ill;
        rd = ins[11:8];
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_before: got %b expected 1", InReady);
        end
        if (dbg_stage == 0) ref_rf[dbg_addr] = dbg_data;
        a   = ref_rf[rd];
        b   = ref_rf[ins[3:0]];
        r   = alu_eval(a, b, ins);
        c   = r[15:0];
        f   = r[20:16];
        we  = model_writes(ins);
        ill = model_illegal(ins);
        InValid  = 1'b1;
        InInstr  = ins;
        DbgWe    = (dbg_stage == 0);
        DbgAddr  = dbg_addr;
        DbgWData = dbg_data;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            InValid = junk && (cyc < 4);
            InInstr = 16'($urandom);
            DbgWe   = (dbg_stage == cyc) && (cyc < 4);
            DbgAddr = (cyc == 4) ? rd : dbg_addr;
            #1;
            checks++;
            if (Done !== (cyc == 3)) begin
                errors++;
                $display("FAIL done_c%0d op=%h: got %b expected %b", cyc, ins, Done, cyc == 3);
            end
            checks++;
            if (Illegal !== (ill && cyc == 3)) begin
                errors++;
                $display("FAIL illegal_c%0d op=%h: got %b expected %b", cyc, ins, Illegal, ill && cyc == 3);
            end
            checks++;
            if (InReady !== (cyc == 4)) begin
                errors++;
                $display("FAIL ready_c%0d op=%h: got %b expected %b", cyc, ins, InReady, cyc == 4);
            end
            if (cyc == 2 || cyc == 4) begin
                checks++;
                if (AluA !== a || AluB !== b || AluOp !== ins) begin
                    errors++;
                    $display("FAIL operands_c%0d: got %h/%h/%h expected %h/%h/%h", cyc, AluA, AluB, AluOp, a, b, ins);
                end
            end
            if (cyc == 4) begin
                if (we) ref_rf[rd] = c;
                ref_psr = f;
                checks++;
                if (Psr !== ref_psr) begin
                    errors++;
                    $display("FAIL psr op=%h: got %b expected %b", ins, Psr, ref_psr);
                end
                checks++;
                if (DbgRData !== ref_rf[rd]) begin
                    errors++;
                    $display("FAIL writeback op=%h R%0d: got %h expected %h", ins, rd, DbgRData, ref_rf[rd]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        InValid  = 1'b0;
        InInstr  = '0;
        DbgWe    = 1'b0;
        DbgAddr  = '0;
        DbgWData = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1 || Done !== 1'b0 || Illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b done=%b ill=%b expected 1/0/0", InReady, Done, Illegal);
        end
        checks++;
        if (Psr !== 5'b0 || AluA !== 16'h0 || AluB !== 16'h0 || AluOp !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs_out: got %b %h %h %h expected all zero", Psr, AluA, AluB, AluOp);
        end
        foreach (ref_rf[i]) ref_rf[i] = '0;
        ref_psr = '0;
        check_all_regs("reset_rf");
    endtask

    task automatic test_add_overflow();
        dbg_write(4'd1, 16'h7FFF);
        dbg_write(4'd2, 16'h0001);
        run_instr({RTYPE, 4'd1, EXT_ADD, 4'd2}, 1'b0, -1, 4'd0, 16'h0);
        DbgAddr = 4'd1;
        #1;
        checks++;
        if (DbgRData !== 16'h8000) begin
            errors++;
            $display("FAIL add_result: got %h expected 8000", DbgRData);
        end
        checks++;
        if (Psr[FLAG_F] !== 1'b1 || Psr[CARRY_F] !== 1'b0) begin
            errors++;
            $display("FAIL add_flags: got psr=%b expected F=1 C=0", Psr);
        end
    endtask

    task automatic test_cmpi();
        dbg_write(4'd3, 16'h0005);
        run_instr({CMPI, 4'd3, 8'h05}, 1'b0, -1, 4'd0, 16'h0);
        DbgAddr = 4'd3;
        #1;
        checks++;
        if (DbgRData !== 16'h0005 || Psr[ZERO_F] !== 1'b1) begin
            errors++;
            $display("FAIL cmpi: got R3=%h psr=%b expected 0005 Z=1", DbgRData, Psr);
        end
    endtask

    task automatic test_illegal();
        run_instr({4'hF, 12'($urandom)}, 1'b0, -1, 4'd0, 16'h0);
        checks++;
        if (Psr !== 5'b11111) begin
            errors++;
            $display("FAIL illegal_psr: got %b expected 11111", Psr);
        end
        check_all_regs("illegal_rf");
    endtask

    task automatic test_back_to_back();
        logic [15:0] ia;
        logic [15:0] ib;
        logic [15:0] aa;
        logic [15:0] ab;
        logic [15:0] ba;
        logic [15:0] bb;
        logic [20:0] ra;
        logic [20:0] rb;
        ia = {ADDI, 4'd6, 8'h10};
        ib = {RTYPE, 4'd7, EXT_XOR, 4'd6};
        aa = ref_rf[6];
        ab = ref_rf[0];
        ra = alu_eval(aa, ab, ia);
        ref_rf[6] = ra[15:0];
        ba = ref_rf[7];
        bb = ref_rf[6];
        rb = alu_eval(ba, bb, ib);
        ref_rf[7] = rb[15:0];
        checks++;
        if (InReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: got %b expected 1", InReady);
        end
        InValid = 1'b1;
        InInstr = ia;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) InInstr = ib;
            if (cyc == 5) InValid = 1'b0;
            #1;
            checks++;
            if (InReady !== (cyc == 4 || cyc == 8)) begin
                errors++;
                $display("FAIL b2b_ready_c%0d: got %b expected %b", cyc, InReady, cyc == 4 || cyc == 8);
            end
            checks++;
            if (Done !== (cyc == 3 || cyc == 7)) begin
                errors++;
                $display("FAIL b2b_done_c%0d: got %b expected %b", cyc, Done, cyc == 3 || cyc == 7);
            end
            if (cyc == 2) begin
                checks++;
                if (AluOp !== ia) begin
                    errors++;
                    $display("FAIL b2b_first_op: got %h expected %h", AluOp, ia);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (AluOp !== ib || AluA !== ba || AluB !== bb) begin
                    errors++;
                    $display("FAIL b2b_second: got %h/%h/%h expected %h/%h/%h", AluOp, AluA, AluB, ib, ba, bb);
                end
            end
            if (cyc == 4 || cyc == 8) begin
                ref_psr = (cyc == 4) ? ra[20:16] : rb[20:16];
                checks++;
                if (Psr !== ref_psr) begin
                    errors++;
                    $display("FAIL b2b_psr_c%0d: got %b expected %b", cyc, Psr, ref_psr);
                end
            end
        end
        check_all_regs("b2b_rf");
    endtask

    task automatic test_reset_inflight();
        dbg_write(4'd1, 16'h0001);
        InValid = 1'b1;
        InInstr = {SHIFTS, 4'd1, EXT_LSHI_LEFT, 4'd4};
        @(negedge clk);
        InValid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        DbgAddr = 4'd1;
        #1;
        checks++;
        if (Done !== 1'b0 || InReady !== 1'b1 || DbgRData !== 16'h0 || Psr !== 5'b0) begin
            errors++;
            $display("FAIL rst_exec: got done=%b ready=%b R1=%h psr=%b expected 0/1/0000/0", Done, InReady, DbgRData, Psr);
        end
        foreach (ref_rf[i]) ref_rf[i] = '0;
        ref_psr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (Done !== 1'b0 || InReady !== 1'b1) begin
                errors++;
                $display("FAIL rst_exec_after%0d: got done=%b ready=%b expected 0/1", i, Done, InReady);
            end
        end
        check_all_regs("rst_exec_rf");
    endtask

    task automatic test_dbg();
        dbg_write(4'd4, 16'hAAAA);
        run_instr({CMPI, 4'd5, 8'h00}, 1'b0, 2, 4'd4, 16'h1234);
        DbgAddr = 4'd4;
        #1;
        checks++;
        if (DbgRData !== 16'hAAAA) begin
            errors++;
            $display("FAIL dbg_drop: got %h expected aaaa", DbgRData);
        end
        run_instr({RTYPE, 4'd8, EXT_OR, 4'd9}, 1'b1, 0, 4'd9, 16'h0F0F);
        run_instr({SUBI, 4'd10, 8'h01}, 1'b1, 3, 4'd11, 16'h5555);
        check_all_regs("dbg_rf");
    endtask

    task automatic test_random();
        logic [3:0]  cls;
        logic [3:0]  ext;
        logic [15:0] ins;
        for (int i = 0; i < 16; i++) dbg_write(4'(i), 16'($urandom));
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0, 1: cls = RTYPE;
                2:    cls = ADDI;
                3, 4: cls = SHIFTS;
                5:    cls = SUBI;
                6:    cls = CMPI;
                default: cls = 4'($urandom);
            endcase
            ext = 4'($urandom);
            if (cls == RTYPE) begin
                case ($urandom_range(0, 5))
                    0: ext = EXT_AND;
                    1: ext = EXT_OR;
                    2: ext = EXT_XOR;
                    3: ext = EXT_ADD;
                    4: ext = EXT_CMP;
                    default: ;
                endcase
            end else if (cls == SHIFTS) begin
                case ($urandom_range(0, 3))
                    0: ext = EXT_LSHI_LEFT;
                    1: ext = EXT_LSHI_RIGHT;
                    2: ext = EXT_LSH;
                    default: ;
                endcase
            end
            ins = {cls, 4'($urandom), ext, 4'($urandom)};
            run_instr(ins, 1'($urandom), int'($urandom_range(0, 5)) - 1,
                      4'($urandom), 16'($urandom));
        end
        check_all_regs("random_rf");
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_cmpi();
        test_illegal();
        test_back_to_back();
        test_dbg();
        test_random();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, datapath and register width; fixed at 16.
REQ-002 Parameter: NUM_REGS, 16, register file depth, addressed by 4-bit fields.
REQ-003 clk  input  1  the only clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 InValid  input  1  an instruction word is offered.
REQ-006 InInstr  input  16  instruction word: [15:12] op class, [11:8] Rdest, [7:4] ext/imm-high, [3:0] Rsrc/imm-low.
REQ-007 InReady  output  1  sequencer accepts InInstr this cycle.
REQ-008 AluA  output  16  registered operand to ALU A; holds Rdest contents.
REQ-009 AluB  output  16  registered operand to ALU B; holds Rsrc contents.
REQ-010 AluOp  output  16  registered copy of the accepted instruction, driven to ALU OpCode.
REQ-011 AluC  input  16  ALU result.
REQ-012 AluFlags  input  5  ALU flags, bit positions per `CARRY_FLAG, `LOW_FLAG, `FLAG_FLAG, `ZERO_FLAG, `NEG_FLAG.
REQ-013 Psr  output  5  processor status register.
REQ-014 Done  output  1  one-cycle pulse on instruction retire.
REQ-015 Illegal  output  1  one-cycle pulse, coincident with Done, for an op class outside `RTYPE, `ADDI, `SHIFTS, `SUBI, `CMPI.
REQ-016 DbgAddr  input  4  debug/preload register address.
REQ-017 DbgWe  input  1  debug write strobe; honoured only in IDLE.
REQ-018 DbgWData  input  16  debug write data.
REQ-019 DbgRData  output  16  combinational read of register DbgAddr.

Function
REQ-020 FSM states SHALL be IDLE, READ, EXEC, WB; InReady=1 only in IDLE.
REQ-021 IDLE: InValid=1 latches InInstr and goes to READ; otherwise stays in IDLE.
REQ-022 READ: AluA<=R[Rdest], AluB<=R[Rsrc], AluOp<=latched instruction; go to EXEC.
REQ-023 EXEC: one settle cycle for the combinational ALU; at the end of EXEC, AluC and AluFlags are captured into internal result registers; go to WB.
REQ-024 WB: writeback, PSR update, Done pulse; return to IDLE; accept-to-Done latency is exactly 3 cycles and throughput is one instruction per 4 cycles.
REQ-025 Register write SHALL occur for `RTYPE with ext `EXT_ADD/`EXT_OR/`EXT_XOR/`EXT_AND, `ADDI, `SUBI, and `SHIFTS with any defined shift ext; the target is R[Rdest] and the data is the captured AluC.
REQ-026 No register write for `EXT_CMP, `CMPI, an undefined RTYPE/SHIFTS ext, or an illegal op class.
REQ-027 On every retire, PSR<=captured AluFlags (all 5 bits), including the illegal case (5'b11111).
REQ-028 AluA/AluB/AluOp SHALL hold their values from READ until the next READ.
REQ-029 InValid is ignored outside IDLE; the instruction is not queued.
REQ-030 A DbgWe in IDLE coincident with an accepted instruction: the debug write takes effect and the instruction reads the new value in READ.
REQ-031 A DbgWe outside IDLE SHALL be dropped.
REQ-032 DbgRData reflects a register write from the cycle after the write edge.

Reset
REQ-033 With reset_n=0 at an edge: state<=IDLE, all registers R0-R15<=0, Psr<=0, AluA/AluB/AluOp<=0, Done=0, Illegal=0.
REQ-034 Reset in READ/EXEC/WB drops the in-flight instruction: no writeback, no Done.

Verification
REQ-035 Preload R1=0x7FFF and R2=0x0001, then issue RTYPE EXT_ADD with Rdest=1, Rsrc=2 -> Done 3 cycles after accept; R1=0x8000; Psr FLAG_FLAG=1 and CARRY_FLAG=0.
REQ-036 Preload R3=0x0005, then issue CMPI with Rdest=3, imm=0x05 -> ZERO_FLAG=1, R3 unchanged at 0x0005, Done pulses.
REQ-037 Issue op class 4'hF -> Illegal and Done pulse together; Psr=5'b11111; no register changes.
REQ-038 Hold InValid=1 continuously with two different words -> the second is accepted only on the cycle after the first's Done; InReady is 0 for exactly 3 cycles per instruction.
REQ-039 Preload R1=0x0001, then issue SHIFTS EXT_LSHI_LEFT with amount 4 on R1 and assert reset_n=0 in EXEC -> R1=0, no Done, state IDLE next cycle.
REQ-040 Drive DbgWe=1 during EXEC to R4 with 0x1234 -> R4 stays at its prior value.
